// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the arbiter, the IF/MEM requesters and the unified memory.
// The arbiter takes the slave view; requesters and memory together form the master side.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_abort;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_stall;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_u_b_h_w;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_stall;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_u_b_h_w;
    logic [31:0] mem_rdata;

    logic        busy;
    logic        grant_d;

    modport slave (
        input  if_req, if_addr, if_abort,
        input  d_req, d_we, d_addr, d_wdata, d_u_b_h_w,
        input  mem_rdata,
        output if_ack, if_rdata, if_stall,
        output d_ack, d_rdata, d_stall,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_u_b_h_w,
        output busy, grant_d
    );

    modport master (
        output if_req, if_addr, if_abort,
        output d_req, d_we, d_addr, d_wdata, d_u_b_h_w,
        output mem_rdata,
        input  if_ack, if_rdata, if_stall,
        input  d_ack, d_rdata, d_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_u_b_h_w,
        input  busy, grant_d
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency unified memory between the fetch port and the load/store port.
// Data has priority; a fetch is forced through after STARVE_MAX consecutive data grants.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    localparam logic [3:0] LAT  = 4'(MEM_LAT);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [1:0]  state;
    logic [3:0]  starve_cnt;
    logic [3:0]  lat_cnt;
    logic        abort_flag;
    logic        sel_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  width_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;
    logic        grant_data;
    logic        grant_fetch;

    // Arbitration decision, only meaningful while IDLE samples the requests.
    always_comb begin
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        if (state == IDLE) begin
            if (bus.d_req && (!bus.if_req || starve_cnt != SMAX)) begin
                grant_data = 1'b1;
            end else if (bus.if_req) begin
                grant_fetch = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            lat_cnt    <= 4'd0;
            abort_flag <= 1'b0;
            sel_d      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            width_q    <= 3'd0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    abort_flag <= 1'b0;
                    if (grant_data) begin
                        sel_d   <= 1'b1;
                        we_q    <= bus.d_we;
                        addr_q  <= bus.d_addr;
                        wdata_q <= bus.d_wdata;
                        width_q <= bus.d_u_b_h_w;
                        state   <= ISSUE;
                        if (!bus.if_req) begin
                            starve_cnt <= 4'd0;
                        end else if (starve_cnt != SMAX) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end else if (grant_fetch) begin
                        sel_d      <= 1'b0;
                        we_q       <= 1'b0;
                        addr_q     <= bus.if_addr;
                        wdata_q    <= 32'd0;
                        width_q    <= 3'b010;
                        starve_cnt <= 4'd0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    lat_cnt <= LAT;
                    state   <= WAIT;
                    if (!sel_d && bus.if_abort) begin
                        abort_flag <= 1'b1;
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (!sel_d && bus.if_abort) begin
                        abort_flag <= 1'b1;
                    end
                    // An abort arriving in the capture cycle itself must also suppress the data.
                    if (lat_cnt == 4'd1) begin
                        state <= ACK;
                        if (sel_d) begin
                            if (!we_q) begin
                                d_rdata_q <= bus.mem_rdata;
                            end
                        end else if (!abort_flag && !bus.if_abort) begin
                            if_rdata_q <= bus.mem_rdata;
                        end
                    end
                end
                default: begin
                    abort_flag <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en      = (state == ISSUE);
    assign bus.mem_we      = (state == ISSUE) && we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_u_b_h_w = width_q;

    assign bus.if_ack   = (state == ACK) && !sel_d && !abort_flag;
    assign bus.d_ack    = (state == ACK) && sel_d;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.if_stall = bus.if_req && !bus.if_ack;
    assign bus.d_stall  = bus.d_req && !bus.d_ack;

    assign bus.busy    = (state != IDLE);
    assign bus.grant_d = sel_d;

endmodule
